// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access width codes
// and the byte-mask helper used by the lane logic.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } lsuState_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Lanes touched by an access of the given width at byte offset 0.
    function automatic logic [3:0] baseMask(input logic [1:0] widthCode);
        logic [3:0] mask;
        case (widthCode)
            WIDTH_WORD: mask = 4'b1111;
            WIDTH_HALF: mask = 4'b0011;
            WIDTH_BYTE: mask = 4'b0001;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: shifts the width mask and store data to the addressed
// lanes and flags accesses that would spill into the next word.
module lsu_byte_lane
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  widthCode,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] storeData,
    output logic [3:0]  byteSelect,
    output logic        misaligned,
    output logic        anyLane,
    output logic [31:0] dataWrite
);

    logic [3:0] base;
    logic [6:0] mask7;

    assign base       = baseMask(widthCode);
    assign mask7      = {3'b000, base} << byteOffset;
    assign misaligned = |mask7[6:4];
    assign byteSelect = mask7[3:0];
    assign anyLane    = |base;
    assign dataWrite  = storeData << {byteOffset, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus initiator: one bus cycle per load/store instruction, stalls
// the pipe while the cycle is outstanding and holds the result until the pipe steps.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stepPipe,
    input  logic        accessValid,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        accessStall,
    output logic        accessDone,
    output logic        addressMisaligned,
    output logic        busError,
    output logic [31:0] loadData,
    output logic [31:0] memoryAddress,
    output logic [3:0]  memoryByteSelect,
    output logic        memoryWriteEnable,
    output logic        memoryReadEnable,
    output logic [31:0] memoryDataWrite,
    input  logic        memoryBusy,
    input  logic [31:0] memoryDataRead
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsuState_t   stateReg;
    logic [31:0] addressReg;
    logic [3:0]  byteSelectReg;
    logic [31:0] dataWriteReg;
    logic        writeReg;
    logic [CW-1:0] timeoutCountReg;
    logic        busErrorReg;
    logic        accessDoneReg;
    logic [31:0] loadDataReg;

    logic [3:0]  laneSelect;
    logic [31:0] laneData;
    logic        laneMisaligned;
    logic        laneAny;
    logic        isMemOp;
    logic        request;

    // Sign/unsigned bit only matters to writeback; the bus cycle ignores it.
    logic unusedFunct3;
    assign unusedFunct3 = funct3[2];

    lsu_byte_lane byteLane (
        .widthCode  (funct3[1:0]),
        .byteOffset (address[1:0]),
        .storeData  (storeData),
        .byteSelect (laneSelect),
        .misaligned (laneMisaligned),
        .anyLane    (laneAny),
        .dataWrite  (laneData)
    );

    assign isMemOp = accessValid && (isLoad || isStore);
    assign request = isMemOp && laneAny && !laneMisaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg        <= IDLE;
            addressReg      <= '0;
            byteSelectReg   <= '0;
            dataWriteReg    <= '0;
            writeReg        <= 1'b0;
            timeoutCountReg <= '0;
            busErrorReg     <= 1'b0;
            accessDoneReg   <= 1'b0;
            loadDataReg     <= '0;
        end else begin
            accessDoneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (request) begin
                        addressReg      <= {address[31:2], 2'b00};
                        byteSelectReg   <= laneSelect;
                        dataWriteReg    <= laneData;
                        writeReg        <= isStore;
                        timeoutCountReg <= '0;
                        busErrorReg     <= 1'b0;
                        stateReg        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!memoryBusy) begin
                        if (!writeReg) begin
                            loadDataReg <= memoryDataRead;
                        end
                        accessDoneReg <= 1'b1;
                        stateReg      <= HOLD;
                    end else if (timeoutCountReg == TIMEOUT_LAST) begin
                        busErrorReg   <= 1'b1;
                        accessDoneReg <= 1'b1;
                        stateReg      <= HOLD;
                    end else if (timeoutCountReg != '1) begin
                        timeoutCountReg <= timeoutCountReg + 1'b1;
                    end
                end
                HOLD: begin
                    // Only a pipe step re-arms the unit; a still-valid instruction is not replayed.
                    if (stepPipe) begin
                        stateReg <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign memoryReadEnable  = (stateReg == ACCESS) && !writeReg;
    assign memoryWriteEnable = (stateReg == ACCESS) && writeReg;
    assign accessStall       = (stateReg == ACCESS) || ((stateReg == IDLE) && request);
    assign addressMisaligned = isMemOp && laneMisaligned;
    assign accessDone        = accessDoneReg;
    assign busError          = busErrorReg;
    assign loadData          = loadDataReg;
    assign memoryAddress     = addressReg;
    assign memoryByteSelect  = byteSelectReg;
    assign memoryDataWrite   = dataWriteReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected bus cycles and
// completions, a monitor checks them whenever the DUT presents them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stepPipe;
    logic        accessValid;
    logic        isLoad;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        accessStall;
    logic        accessDone;
    logic        addressMisaligned;
    logic        busError;
    logic [31:0] loadData;
    logic [31:0] memoryAddress;
    logic [3:0]  memoryByteSelect;
    logic        memoryWriteEnable;
    logic        memoryReadEnable;
    logic [31:0] memoryDataWrite;
    logic        memoryBusy;
    logic [31:0] memoryDataRead;

    int checks = 0;
    int fails  = 0;
    logic [31:0] expLoad = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] dw;
        logic        we;
        logic        re;
    } busExp_t;

    typedef struct {
        logic [31:0] ld;
        logic        be;
    } doneExp_t;

    busExp_t  busQ[$];
    doneExp_t doneQ[$];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .stepPipe          (stepPipe),
        .accessValid       (accessValid),
        .isLoad            (isLoad),
        .isStore           (isStore),
        .funct3            (funct3),
        .address           (address),
        .storeData         (storeData),
        .accessStall       (accessStall),
        .accessDone        (accessDone),
        .addressMisaligned (addressMisaligned),
        .busError          (busError),
        .loadData          (loadData),
        .memoryAddress     (memoryAddress),
        .memoryByteSelect  (memoryByteSelect),
        .memoryWriteEnable (memoryWriteEnable),
        .memoryReadEnable  (memoryReadEnable),
        .memoryDataWrite   (memoryDataWrite),
        .memoryBusy        (memoryBusy),
        .memoryDataRead    (memoryDataRead)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    initial begin : monitor
        bit       prevEn;
        busExp_t  b;
        doneExp_t d;
        prevEn = 1'b0;
        forever begin
            @(negedge clk);
            if ((memoryReadEnable || memoryWriteEnable) && !prevEn) begin
                if (busQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected bus cycle: addr 0x%08h, none expected", memoryAddress);
                end else begin
                    b = busQ.pop_front();
                    check("bus address", memoryAddress, b.addr);
                    check("bus byteSelect", {28'h0, memoryByteSelect}, {28'h0, b.sel});
                    check("bus dataWrite", memoryDataWrite, b.dw);
                    check("bus writeEnable", {31'h0, memoryWriteEnable}, {31'h0, b.we});
                    check("bus readEnable", {31'h0, memoryReadEnable}, {31'h0, b.re});
                end
            end
            prevEn = memoryReadEnable || memoryWriteEnable;
            if (accessDone) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected accessDone: loadData 0x%08h, none expected", loadData);
                end else begin
                    d = doneQ.pop_front();
                    check("done loadData", loadData, d.ld);
                    check("done busError", {31'h0, busError}, {31'h0, d.be});
                end
            end
        end
    end

    task automatic clearInputs();
        accessValid = 1'b0;
        isLoad      = 1'b0;
        isStore     = 1'b0;
        funct3      = 3'b000;
        address     = 32'h0;
        storeData   = 32'h0;
    endtask

    // One full access: request cycle, ACCESS cycles with busyN busy cycles, lands in HOLD.
    task automatic doAccess(input string name, input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data, input int busyN,
                            input logic [31:0] rdata, input logic [3:0] expSel,
                            input logic [31:0] expDw, input int expStall, input bit expBe);
        busExp_t  b;
        doneExp_t d;
        int       stallCnt;
        b.addr = {addr[31:2], 2'b00};
        b.sel  = expSel;
        b.dw   = expDw;
        b.we   = st;
        b.re   = !st;
        busQ.push_back(b);
        if (!st && !expBe) expLoad = rdata;
        d.ld = expLoad;
        d.be = expBe;
        doneQ.push_back(d);

        @(posedge clk); #1;
        accessValid    = 1'b1;
        isLoad         = ld;
        isStore        = st;
        funct3         = f3;
        address        = addr;
        storeData      = data;
        memoryBusy     = (busyN > 0);
        memoryDataRead = 32'h0;
        @(negedge clk);
        check({name, " stall in request cycle"}, {31'h0, accessStall}, 32'h1);
        @(posedge clk); #1;
        clearInputs();
        stallCnt = 0;
        for (int k = 0; k < 20; k++) begin
            memoryBusy     = (k < busyN);
            memoryDataRead = (k < busyN) ? (32'hBAD0_0000 + k) : rdata;
            @(negedge clk);
            if (!accessStall) break;
            stallCnt++;
            @(posedge clk); #1;
        end
        check({name, " stall cycles"}, stallCnt, expStall);
        check({name, " busError in HOLD"}, {31'h0, busError}, {31'h0, expBe});
    endtask

    // Sit in HOLD with a new load offered (must be ignored), then step the pipe.
    task automatic holdAndStep(input string name, input int nHold);
        for (int n = 0; n < nHold; n++) begin
            @(posedge clk); #1;
            accessValid = 1'b1;
            isLoad      = 1'b1;
            funct3      = 3'b010;
            address     = 32'h7000_0000;
            memoryDataRead = 32'h5555_AAAA;
            @(negedge clk);
            check({name, " HOLD stall"}, {31'h0, accessStall}, 32'h0);
            check({name, " HOLD loadData"}, loadData, expLoad);
        end
        @(posedge clk); #1;
        clearInputs();
        stepPipe   = 1'b1;
        memoryBusy = 1'b0;
        @(posedge clk); #1;
        stepPipe = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst            = 1'b1;
        stepPipe       = 1'b0;
        memoryBusy     = 1'b0;
        memoryDataRead = 32'h0;
        clearInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset accessStall", {31'h0, accessStall}, 32'h0);
        check("reset accessDone", {31'h0, accessDone}, 32'h0);
        check("reset busError", {31'h0, busError}, 32'h0);
        check("reset loadData", loadData, 32'h0);
        check("reset memoryAddress", memoryAddress, 32'h0);
        check("reset byteSelect", {28'h0, memoryByteSelect}, 32'h0);
        check("reset enables", {30'h0, memoryReadEnable, memoryWriteEnable}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        doAccess("SW", 1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 0, 32'h0,
                 4'b1111, 32'hDEAD_BEEF, 1, 1'b0);
        holdAndStep("SW", 1);

        doAccess("SB", 1'b0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_00A5, 0, 32'h0,
                 4'b1000, 32'hA500_0000, 1, 1'b0);
        holdAndStep("SB", 1);

        @(posedge clk); #1;
        accessValid = 1'b1;
        isLoad      = 1'b1;
        funct3      = 3'b001;
        address     = 32'h1000_0003;
        @(negedge clk);
        check("LH misaligned flag", {31'h0, addressMisaligned}, 32'h1);
        check("LH misaligned stall", {31'h0, accessStall}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("LH misaligned no read", {31'h0, memoryReadEnable}, 32'h0);
        @(posedge clk); #1;
        funct3 = 3'b011;
        address = 32'h1000_0000;
        @(negedge clk);
        check("funct3 011 stall", {31'h0, accessStall}, 32'h0);
        check("funct3 011 misaligned", {31'h0, addressMisaligned}, 32'h0);
        @(posedge clk); #1;
        clearInputs();

        doAccess("LH", 1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0, 0, 32'hCAFE_0000,
                 4'b1100, 32'h0, 1, 1'b0);
        holdAndStep("LH", 1);

        doAccess("LW busy3", 1'b1, 1'b0, 3'b010, 32'h2000_0008, 32'h0, 3, 32'h1234_5678,
                 4'b1111, 32'h0, 4, 1'b0);
        holdAndStep("LW busy3", 3);

        doAccess("LW timeout", 1'b1, 1'b0, 3'b010, 32'h3000_0000, 32'h0, 100, 32'h0,
                 4'b1111, 32'h0, 4, 1'b1);
        holdAndStep("LW timeout", 2);

        doAccess("LBU", 1'b1, 1'b0, 3'b100, 32'h5000_0001, 32'h0, 0, 32'h0000_AB00,
                 4'b0010, 32'h0, 1, 1'b0);
        holdAndStep("LBU", 1);

        // Reset in the middle of a busy load: bus cycle seen, no completion.
        begin
            busExp_t b;
            b.addr = 32'h4000_0000;
            b.sel  = 4'b1111;
            b.dw   = 32'h0;
            b.we   = 1'b0;
            b.re   = 1'b1;
            busQ.push_back(b);
        end
        @(posedge clk); #1;
        accessValid = 1'b1;
        isLoad      = 1'b1;
        funct3      = 3'b010;
        address     = 32'h4000_0000;
        memoryBusy  = 1'b1;
        @(posedge clk); #1;
        clearInputs();
        @(negedge clk);
        check("pre-reset readEnable", {31'h0, memoryReadEnable}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid-reset enables", {30'h0, memoryReadEnable, memoryWriteEnable}, 32'h0);
        check("mid-reset stall", {31'h0, accessStall}, 32'h0);
        @(posedge clk); #1;
        rst        = 1'b0;
        memoryBusy = 1'b0;
        expLoad    = 32'h0;
        @(negedge clk);
        check("post-reset stall", {31'h0, accessStall}, 32'h0);
        check("post-reset loadData", loadData, 32'h0);

        doAccess("LW after reset", 1'b1, 1'b0, 3'b010, 32'h6000_000C, 32'h0, 0, 32'h0BAD_F00D,
                 4'b1111, 32'h0, 1, 1'b0);
        holdAndStep("LW after reset", 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bus queue drained", busQ.size(), 32'h0);
        check("done queue drained", doneQ.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
